// File: rtl/line_sequencer.sv
// Frame sequencer: fetches each line from the input memory, launches the datapath,
// waits for done (with a watchdog), and writes the result to the output memory.
module line_sequencer #(
  parameter int LINE_W  = 25,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  output logic              in_ren,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [LINE_W-1:0] in_rdata,
  output logic [LINE_W-1:0] dp_line,
  output logic              dp_start,
  input  logic              dp_done,
  input  logic [LINE_W-1:0] dp_result,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [LINE_W-1:0] out_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] line_idx,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAITRD, S_LAUNCH, S_RUN, S_STORE, S_FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  WD_MAX   = CNT_W'(TIMEOUT);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]    wdog, wdog_nxt;
  logic [LINE_W-1:0]   line_nxt;
  logic [LINE_W-1:0]   result;
  logic                terr_nxt;

  assign line_idx = idx;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wdog_nxt  = wdog;
    line_nxt  = dp_line;
    result    = '0;
    terr_nxt  = timeout_err;
    unique case (state)
      S_IDLE: begin
        if (go) begin
          idx_nxt   = '0;
          terr_nxt  = 1'b0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH:  state_nxt = S_WAITRD;
      S_WAITRD: begin
        line_nxt  = in_rdata;
        state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        wdog_nxt  = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        // done wins over an expiring watchdog in the same cycle
        if (dp_done) begin
          result    = dp_result;
          state_nxt = S_STORE;
        end else if (wdog == WD_MAX) begin
          result    = '1;
          terr_nxt  = 1'b1;
          state_nxt = S_STORE;
        end else begin
          wdog_nxt  = wdog + 1'b1;
        end
      end
      S_STORE: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_FINISH;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FINISH: begin
        if (!go) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      terr_nxt  = timeout_err;
    end
  end

  // Outputs are decoded from the next state so every one of them is a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      wdog        <= '0;
      dp_line     <= '0;
      out_wdata   <= '0;
      out_addr    <= '0;
      in_addr     <= '0;
      in_ren      <= 1'b0;
      dp_start    <= 1'b0;
      out_we      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      wdog        <= wdog_nxt;
      dp_line     <= line_nxt;
      timeout_err <= terr_nxt;
      in_ren      <= (state_nxt == S_FETCH);
      dp_start    <= (state_nxt == S_LAUNCH);
      out_we      <= (state_nxt == S_STORE);
      busy        <= (state_nxt != S_IDLE) && (state_nxt != S_FINISH);
      frame_done  <= (state_nxt == S_FINISH);
      if (state_nxt == S_FETCH) in_addr <= idx_nxt;
      if (state_nxt == S_STORE) begin
        out_addr  <= idx_nxt;
        out_wdata <= result;
      end
    end
  end

endmodule
